// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_W = 32;
    localparam int OFFS_W = 2;

    function automatic logic is_misaligned(input logic [OFFS_W-1:0] offs);
        return (offs != {OFFS_W{1'b0}});
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and registered read; no reset on contents or read data.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
)
(
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_r;

    // write port and registered read port share one address
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY response, pipeline stall.
// Optional misalignment detection is enabled with the DMEM_ERR_EN macro.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_stall
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dmem_state_t       state_r;
    dmem_state_t       next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              write_r;
    logic [AW+1:0]     addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic              ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic              resp_load_r;

    logic              accept_s;
    logic              enter_resp_s;
    logic              sel_write_s;
    logic [AW+1:0]     sel_addr_s;
    logic [WORD_W-1:0] sel_wdata_s;
    logic              err_s;
    logic              arr_we_s;
    logic              arr_re_s;
    logic [WORD_W-1:0] arr_rdata_s;
    logic [WORD_W-1:0] rdata_s;
    logic              stall_s;
    logic              unused_s;

    // next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = (LATENCY > 1) ? ST_BUSY : ST_RESP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the array access happens on the accept edge itself, so it must use the live request.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && req_valid;
        enter_resp_s = (next_state_s == ST_RESP);
        if (state_r == ST_IDLE) begin
            sel_write_s = req_write;
            sel_addr_s  = req_addr[AW+1:0];
            sel_wdata_s = req_wdata;
        end else begin
            sel_write_s = write_r;
            sel_addr_s  = addr_r;
            sel_wdata_s = wdata_r;
        end
`ifdef DMEM_ERR_EN
        err_s = is_misaligned(sel_addr_s[OFFS_W-1:0]);
`else
        err_s = 1'b0;
`endif
        arr_we_s = enter_resp_s && sel_write_s && !err_s;
        arr_re_s = enter_resp_s && !sel_write_s && !err_s;
    end

    // stall: waiting request in IDLE, or an access in flight
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = req_valid;
            ST_BUSY: stall_s = 1'b1;
            ST_RESP: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // state, counter, request latch and registered response flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            write_r      <= 1'b0;
            addr_r       <= {(AW+2){1'b0}};
            wdata_r      <= {WORD_W{1'b0}};
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_load_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            ready_r      <= (next_state_s == ST_IDLE);
            resp_valid_r <= enter_resp_s;
            resp_err_r   <= enter_resp_s && err_s;
            resp_load_r  <= arr_re_s;
            if (accept_s) begin
                cnt_r   <= CNT_LOAD;
                write_r <= req_write;
                addr_r  <= req_addr[AW+1:0];
                wdata_r <= req_wdata;
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    // stores and errored loads return zero data
    always_comb begin
        if (resp_load_r) begin
            rdata_s = arr_rdata_s;
        end else begin
            rdata_s = {WORD_W{1'b0}};
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .addr  (sel_addr_s[AW+1:2]),
        .wdata (sel_wdata_s),
        .rdata (arr_rdata_s)
    );

    assign unused_s   = &{1'b0, req_addr[WORD_W-1:AW+2], sel_addr_s[OFFS_W-1:0]};
    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = rdata_s;
    assign mem_stall  = stall_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: reference model for a LATENCY=2 instance
// plus directed checks on a LATENCY=1 instance.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_stall;
    logic [31:0] resp_rdata;

    logic        r1_valid = 1'b0;
    logic        r1_write = 1'b0;
    logic [31:0] r1_addr  = 32'h0;
    logic [31:0] r1_wdata = 32'h0;
    logic        r1_ready, r1_resp_valid, r1_err, r1_stall;
    logic [31:0] r1_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_stall(mem_stall)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(r1_ready),
        .req_write(r1_write), .req_addr(r1_addr), .req_wdata(r1_wdata),
        .resp_valid(r1_resp_valid), .resp_rdata(r1_rdata), .resp_err(r1_err),
        .mem_stall(r1_stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request is taken when it is present and LAT+1 edges have passed since
    // the previous accept; its memory effect and response data are fixed LAT-1 edges later.
    logic [31:0] mem_m [int];
    int          e_cnt     = 0;
    int          next_free = 0;
    bit          pend      = 1'b0;
    int          p_e       = 0;
    bit          p_w       = 1'b0;
    logic [31:0] p_a       = 32'h0;
    logic [31:0] p_d       = 32'h0;
    bit          m_idle    = 1'b1;
    bit          m_resp    = 1'b0;
    bit          m_known   = 1'b0;
    bit          m_err     = 1'b0;
    logic [31:0] m_rdata   = 32'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_free = 0;
            pend      = 1'b0;
            m_resp    = 1'b0;
            m_idle    = 1'b1;
        end else begin
            int idx;
            e_cnt  = e_cnt + 1;
            m_resp = 1'b0;
            if (req_valid && e_cnt >= next_free) begin
                pend      = 1'b1;
                p_e       = e_cnt;
                p_w       = req_write;
                p_a       = req_addr;
                p_d       = req_wdata;
                next_free = e_cnt + LAT + 1;
            end
            if (pend && e_cnt == p_e + LAT - 1) begin
                idx = int'(p_a[11:2]);
`ifdef DMEM_ERR_EN
                m_err = (p_a[1:0] != 2'b00);
`else
                m_err = 1'b0;
`endif
                if (p_w || m_err) begin
                    if (p_w && !m_err) mem_m[idx] = p_d;
                    m_rdata = 32'h0;
                    m_known = 1'b1;
                end else if (mem_m.exists(idx)) begin
                    m_rdata = mem_m[idx];
                    m_known = 1'b1;
                end else begin
                    m_known = 1'b0;
                end
                m_resp = 1'b1;
                pend   = 1'b0;
            end
            m_idle = (e_cnt + 1 >= next_free);
        end
    end

    // compare the LATENCY=2 instance against the model every cycle
    always @(negedge clk) begin
        chk("ready", {31'b0, req_ready}, {31'b0, m_idle});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_resp});
        chk("stall", {31'b0, mem_stall}, {31'b0, (m_idle ? req_valid : !m_resp)});
        if (m_resp) begin
            chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
            if (m_known) chk("resp_rdata", resp_rdata, m_rdata);
        end
    end

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_stall;
    int          last_lat;

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        last_stall = 0;
        last_lat = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_stall) last_stall++;
            if (req_ready) begin got = 1'b1; break; end
        end
        chk("accepted", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            last_lat++;
            if (mem_stall) last_stall++;
            if (resp_valid) begin
                got = 1'b1;
                last_rdata = resp_rdata;
                last_err = resp_err;
                break;
            end
        end
        chk("responded", {31'b0, got}, 32'd1);
    endtask

    initial begin
        int acc;
        int rsp;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // store then load, LATENCY=2
        do_req(1'b1, 32'h40, 32'h12345678);
        chk("st_latency", last_lat, LAT);
        chk("st_stall_cycles", last_stall, 32'd2);
        chk("st_rdata_zero", last_rdata, 32'h0);
        do_req(1'b0, 32'h40, 32'h0);
        chk("ld_latency", last_lat, LAT);
        chk("ld_stall_cycles", last_stall, 32'd2);
        chk("ld_rdata", last_rdata, 32'h12345678);

        // aliasing modulo 1024 words
        do_req(1'b1, 32'h0000_1004, 32'hA5A5A5A5);
        do_req(1'b0, 32'h0000_0004, 32'h0);
        chk("alias_rdata", last_rdata, 32'hA5A5A5A5);

        // reset while a store is in BUSY
        do_req(1'b1, 32'h10, 32'h11112222);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (3) @(posedge clk);
        do_req(1'b0, 32'h10, 32'h0);
        chk("rst_store_dropped", last_rdata, 32'h11112222);

        // misaligned store
        do_req(1'b1, 32'h42, 32'h00000001);
`ifdef DMEM_ERR_EN
        chk("mis_err", {31'b0, last_err}, 32'd1);
`else
        chk("mis_err", {31'b0, last_err}, 32'd0);
`endif
        do_req(1'b0, 32'h40, 32'h0);
`ifdef DMEM_ERR_EN
        chk("mis_unchanged", last_rdata, 32'h12345678);
`else
        chk("mis_written", last_rdata, 32'h00000001);
`endif

        // held request: accepts only in IDLE, every LAT+1 cycles
        acc = 0; rsp = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req_ready) acc++;
            if (resp_valid) rsp++;
        end
        @(posedge clk); #1; req_valid = 1'b0;
        chk("held_accepts", acc, 32'd2);
        chk("held_responses", rsp, 32'd2);

        // LATENCY=1 instance: store, then held back-to-back loads
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 32'h8; r1_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("l1_st_ready", {31'b0, r1_ready}, 32'd1);
        chk("l1_st_stall", {31'b0, r1_stall}, 32'd1);
        @(posedge clk); #1; r1_valid = 1'b0;
        @(negedge clk);
        chk("l1_st_resp", {31'b0, r1_resp_valid}, 32'd1);
        chk("l1_st_ready_resp", {31'b0, r1_ready}, 32'd0);
        chk("l1_st_stall_resp", {31'b0, r1_stall}, 32'd0);
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 32'h8;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("l1_ready_seq", {31'b0, r1_ready}, {31'b0, (k % 2 == 0)});
            chk("l1_resp_seq", {31'b0, r1_resp_valid}, {31'b0, (k % 2 == 1)});
            if (r1_ready) acc++;
            if (r1_resp_valid) chk("l1_rdata", r1_rdata, 32'hCAFEF00D);
        end
        @(posedge clk); #1; r1_valid = 1'b0;
        chk("l1_accepts", acc, 32'd3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving load/store requests issued by the pipeline's MEM stage. It accepts one request at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. While a request is outstanding it raises a stall signal that the hazard logic uses to freeze the pipeline. It is the memory-side end of the processor's data-access interface.

## Interface

- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- LATENCY, 2: cycles from the accept edge to `resp_valid`; at least 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present; must be held with stable fields until accepted.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response valid for exactly one cycle.
- resp_rdata  out  32  load data; 0 for stores.
- resp_err  out  1  misaligned access flag; only meaningful with `DMEM_ERR_EN`.
- mem_stall  out  1  pipeline freeze request.

## Operation

- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` the responder accepts the request: it latches write, address and wdata, and loads the counter with LATENCY-1.
  - Next state is BUSY if LATENCY>1, otherwise RESP.
- **BUSY**
  - `req_ready`=0.
  - The counter decrements each cycle.
  - When the counter is 1, next state is RESP.
- **RESP**
  - `resp_valid`=1 and `req_ready`=0.
  - Next state is IDLE unconditionally.
  - There is no back-pressure on responses.
- **Stores:** the array write commits on the edge entering RESP.
- **Loads:** `resp_rdata` is the array word read at that same edge, registered.
- **Address mapping:**
  - Word index is `req_addr[log2(DEPTH_WORDS)+1:2]`.
  - Upper bits are ignored, so addresses alias modulo the array size.
- **Stall:** `mem_stall` = (`req_valid` in IDLE) OR BUSY. It is 0 in RESP, so the pipeline advances in the response cycle.
- **Store-then-load:** a store followed by a load to the same word returns the new data, because the commit precedes the next accept.

## Timing

- **Reset values:** state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0, latched request fields=0.
- **Memory contents:** not reset.
- **Latency:** accept at edge N, then `resp_valid` is high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- **Throughput:** one request per LATENCY+1 cycles.
- **Held requests:** `req_valid` held high through RESP is not re-accepted until IDLE. The MEM stage must drop or replace the request in the cycle `resp_valid` is high.
- **Reset mid-operation:**
  - The outstanding request is dropped.
  - A store in BUSY never commits.
  - A store in RESP has already committed.
  - No response is issued after reset releases.

## Configuration

- Macro: `DMEM_ERR_EN`.
- **Defined:**
  - A request with `req_addr[1:0]`≠0 is still accepted normally and follows the full LATENCY.
  - In RESP, `resp_err`=1 and `resp_rdata`=0.
  - A misaligned store is suppressed and the array is unchanged.
- **Undefined:**
  - `req_addr[1:0]` is ignored, so the access goes to the containing word.
  - `resp_err` is tied 0.

## Structure

- Shared package `dmem_pkg`:
  - FSM state enum (IDLE/BUSY/RESP).
  - Word width constant (32).
  - Byte-offset width constant (2).
- Sub-module `dmem_array`: single-port word RAM of DEPTH_WORDS entries with synchronous write and synchronous read. It has no reset.
- The top instantiates `dmem_array` and contains the FSM, counter and request latch.

## Test plan

- **Reset:** assert `rst`=0 mid-BUSY on a store to 0x10 of 0xDEADBEEF; release, then load 0x10 → the old contents return. During reset `req_ready`=1 and `resp_valid`=0.
- **Store/load, LATENCY=2:** store 0x12345678 to 0x40, then load 0x40 → `resp_valid` 2 cycles after each accept, `resp_rdata`=0x12345678, `mem_stall` high for exactly 2 cycles per access.
- **LATENCY=1:** back-to-back loads with `req_valid` held → accepts every 2 cycles, each response 1 cycle after its accept.
- **Aliasing:** DEPTH_WORDS=1024; store 0xA5A5A5A5 to 0x0000_1004, then load 0x0000_0004 → returns 0xA5A5A5A5.
- **With `DMEM_ERR_EN`:** store 0x1 to 0x42 → `resp_err`=1; a subsequent aligned load of 0x40 returns the unchanged value. Without the macro, the same store writes 0x40 and `resp_err`=0.
- **Held request:** `req_valid` held high across RESP → no duplicate accept in RESP. The second accept occurs only in the following IDLE cycle.
